lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles mem_valid stays asserted without mem_ready before fault; legal range 2..255.
REQ-002 SHALL have port clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  pipeline presents a load/store.
REQ-005 SHALL have port req_ready  out  1  controller can accept a request this cycle.
REQ-006 SHALL have port req_store  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-010 SHALL have port mem_valid  out  1  memory request active.
REQ-011 SHALL have port mem_ready  in  1  memory completes the access this cycle; mem_rdata valid.
REQ-012 SHALL have port mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-013 SHALL have port mem_wdata  out  32  lane-replicated store data.
REQ-014 SHALL have port mem_wstrb  out  4  store byte strobes; 0 for loads.
REQ-015 SHALL have port mem_rdata  in  32  raw read word.
REQ-016 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-017 SHALL have port rsp_byteenable  out  4  lane mask for the load aligner.
REQ-018 SHALL have port rsp_ldata  out  32  captured raw read word for the load aligner.
REQ-019 SHALL have port rsp_misalign  out  1  access rejected as misaligned/illegal size.
REQ-020 SHALL have port rsp_fault  out  1  access abandoned on timeout.

Function
REQ-021 SHALL implement states IDLE and BUSY; req_ready = 1 exactly when state is IDLE.
REQ-022 SHALL accept a request on a cycle with req_valid & req_ready, registering address, byteenable, wdata, wstrb.
REQ-023 SHALL compute byteenable: byte -> 4'b0001 << addr[1:0]; half -> 4'h3 (addr[1:0]=0), 4'hC (=2), else misaligned; word -> 4'hF (addr[1:0]=0), else misaligned; size 11 -> misaligned.
REQ-024 SHALL form mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata; mem_wstrb = byteenable for stores, 0 for loads.
REQ-025 SHALL, on accepting an aligned request, enter BUSY and drive mem_valid = 1 from the next cycle with mem_addr/mem_wdata/mem_wstrb held stable until completion.
REQ-026 SHALL, on accepting a misaligned request, stay IDLE, issue no memory access, and pulse rsp_valid with rsp_misalign = 1, rsp_byteenable = 0, rsp_ldata = 0 the next cycle.
REQ-027 SHALL, in BUSY with mem_ready = 1, capture mem_rdata (loads) or 0 (stores) into rsp_ldata, return to IDLE, and pulse rsp_valid the next cycle with rsp_byteenable = accepted mask.
REQ-028 SHALL count BUSY cycles with mem_ready = 0 from 0; when count = TIMEOUT-1 and mem_ready = 0, drop mem_valid, return to IDLE, pulse rsp_valid next cycle with rsp_fault = 1, rsp_ldata = 0.
REQ-029 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-030 SHALL ignore mem_ready while IDLE.
REQ-031 SHALL allow back-to-back requests: a new request is accepted in the cycle rsp_valid of the previous one is high.
REQ-032 SHALL have minimum latency accept -> rsp_valid of 2 cycles (mem_ready on first BUSY cycle), 1 cycle for misaligned.
REQ-033 SHALL keep rsp_misalign, rsp_fault, rsp_byteenable, rsp_ldata valid only while rsp_valid = 1, and 0 otherwise.

Reset
REQ-034 SHALL, with reset = 1 at a rising edge, force state IDLE, counter 0, and all outputs 0 except req_ready = 1.
REQ-035 SHALL, on reset mid-BUSY, drop mem_valid the following cycle and emit no rsp_valid for the aborted access.

Verification
REQ-036 SHALL cover: lb addr 0x1002, mem_ready on 1st BUSY cycle, rdata 0xAABBCCDD -> rsp_valid 2 cycles after accept, byteenable 4'h4, rsp_ldata 0xAABBCCDD.
REQ-037 SHALL cover: sh addr 0x2002 wdata 0x1234 -> mem_addr 0x2000, mem_wdata 0x12341234, mem_wstrb 4'hC.
REQ-038 SHALL cover: lw addr 0x3001 -> no mem_valid, rsp_valid next cycle with rsp_misalign = 1.
REQ-039 SHALL cover: TIMEOUT=16, mem_ready held 0 -> mem_valid high exactly 16 cycles, then rsp_fault = 1; repeat with mem_ready on 16th cycle -> normal completion, rsp_fault = 0.
REQ-040 SHALL cover: reset asserted on 3rd BUSY cycle -> mem_valid 0 next cycle, no rsp_valid, req_ready = 1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes a pipeline load/store into one word-aligned
// memory access, waits for completion or timeout, and returns a one-cycle response.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [3:0]  rsp_byteenable,
  output logic [31:0] rsp_ldata,
  output logic        rsp_misalign,
  output logic        rsp_fault
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  be_q, be_d;
  logic        store_q, store_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_mis_q, rsp_mis_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [3:0]  rsp_be_q, rsp_be_d;
  logic [31:0] rsp_ldata_q, rsp_ldata_d;

  logic [3:0]  be_dec;
  logic        mis_dec;
  logic [31:0] wdata_rep;

  always_comb begin
    be_dec    = 4'h0;
    mis_dec   = 1'b0;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        be_dec    = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wdata_rep = {2{req_wdata[15:0]}};
        if (req_addr[1:0] == 2'd0)      be_dec  = 4'h3;
        else if (req_addr[1:0] == 2'd2) be_dec  = 4'hC;
        else                            mis_dec = 1'b1;
      end
      2'b10: begin
        if (req_addr[1:0] == 2'd0) be_dec  = 4'hF;
        else                       mis_dec = 1'b1;
      end
      default: mis_dec = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    be_d        = be_q;
    store_d     = store_q;
    // Response fields are single-cycle pulses; they clear unless set below.
    rsp_valid_d = 1'b0;
    rsp_mis_d   = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_be_d    = 4'h0;
    rsp_ldata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (mis_dec) begin
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 8'd0;
            addr_d  = {req_addr[31:2], 2'b00};
            wdata_d = wdata_rep;
            wstrb_d = req_store ? be_dec : 4'h0;
            be_d    = be_dec;
            store_d = req_store;
          end
        end
      end
      BUSY: begin
        // Completion wins over a timeout landing on the same cycle.
        if (mem_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_be_d    = be_q;
          rsp_ldata_d = store_q ? 32'h0 : mem_rdata;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      be_q        <= 4'h0;
      store_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_be_q    <= 4'h0;
      rsp_ldata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      be_q        <= be_d;
      store_q     <= store_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_be_q    <= rsp_be_d;
      rsp_ldata_q <= rsp_ldata_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign mem_valid      = (state_q == BUSY);
  assign mem_addr       = mem_valid ? addr_q  : 32'h0;
  assign mem_wdata      = mem_valid ? wdata_q : 32'h0;
  assign mem_wstrb      = mem_valid ? wstrb_q : 4'h0;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_misalign   = rsp_mis_q;
  assign rsp_fault      = rsp_fault_q;
  assign rsp_byteenable = rsp_be_q;
  assign rsp_ldata      = rsp_ldata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, hand-written timeout/reset
// sequences, and random back-to-back traffic against a reference model.
module tb_lsu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_misalign, rsp_fault;
  logic [3:0]  rsp_byteenable;
  logic [31:0] rsp_ldata;

  int checks = 0;
  int failures = 0;

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_byteenable(rsp_byteenable), .rsp_ldata(rsp_ldata),
    .rsp_misalign(rsp_misalign), .rsp_fault(rsp_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        store;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic [31:0] ldata;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_size = sz; req_addr = a; req_wdata = wd;
  endtask

  // Reference model: access width in bytes, alignment by modulo, mask by shift.
  function automatic logic [4:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int nb  = 1 << sz;
    int off = int'(a[1:0]);
    if (sz == 2'd3 || (off % nb) != 0) return 5'b1_0000;
    return {1'b0, 4'(((1 << nb) - 1) << off)};
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int nb = 1 << sz;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  initial begin
    tbl[0] = '{"lb_1002",  1'b0, 2'd0, 32'h1002, 32'h0,        32'hAABBCCDD, 1'b0, 4'h4, 32'h1000, 32'h0,        4'h0, 32'hAABBCCDD};
    tbl[1] = '{"sh_2002",  1'b1, 2'd1, 32'h2002, 32'h1234,     32'h0,        1'b0, 4'hC, 32'h2000, 32'h12341234, 4'hC, 32'h0};
    tbl[2] = '{"lw_3001",  1'b0, 2'd2, 32'h3001, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,    32'h0,        4'h0, 32'h0};
    tbl[3] = '{"sb_4003",  1'b1, 2'd0, 32'h4003, 32'h5A,       32'h0,        1'b0, 4'h8, 32'h4000, 32'h5A5A5A5A, 4'h8, 32'h0};
    tbl[4] = '{"sw_5000",  1'b1, 2'd2, 32'h5000, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'h5000, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[5] = '{"lh_6000",  1'b0, 2'd1, 32'h6000, 32'h0,        32'h11223344, 1'b0, 4'h3, 32'h6000, 32'h0,        4'h0, 32'h11223344};
    tbl[6] = '{"lh_6001",  1'b0, 2'd1, 32'h6001, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,    32'h0,        4'h0, 32'h0};
    tbl[7] = '{"sz11_7000",1'b0, 2'd3, 32'h7000, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,    32'h0,        4'h0, 32'h0};
    tbl[8] = '{"sh_8003",  1'b1, 2'd1, 32'h8003, 32'hFFFF,     32'h0,        1'b1, 4'h0, 32'h0,    32'h0,        4'h0, 32'h0};
    tbl[9] = '{"lw_9004",  1'b0, 2'd2, 32'h9004, 32'h0,        32'hCAFEF00D, 1'b0, 4'hF, 32'h9004, 32'h0,        4'h0, 32'hCAFEF00D};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_ldata", rsp_ldata, 32'd0);
    reset = 1'b0;
    step();

    // Directed table
    foreach (tbl[k]) begin
      drive_req(tbl[k].store, tbl[k].size, tbl[k].addr, tbl[k].wdata);
      step();
      req_valid = 1'b0;
      if (tbl[k].mis) begin
        chk({tbl[k].name, "_memvalid"}, 32'(mem_valid), 32'd0);
        chk({tbl[k].name, "_rspvalid"}, 32'(rsp_valid), 32'd1);
        chk({tbl[k].name, "_misalign"}, 32'(rsp_misalign), 32'd1);
        chk({tbl[k].name, "_be"}, 32'(rsp_byteenable), 32'd0);
        chk({tbl[k].name, "_ldata"}, rsp_ldata, 32'd0);
      end else begin
        chk({tbl[k].name, "_memvalid"}, 32'(mem_valid), 32'd1);
        chk({tbl[k].name, "_ready"}, 32'(req_ready), 32'd0);
        chk({tbl[k].name, "_maddr"}, mem_addr, tbl[k].maddr);
        if (tbl[k].store) chk({tbl[k].name, "_mwdata"}, mem_wdata, tbl[k].mwdata);
        chk({tbl[k].name, "_mwstrb"}, 32'(mem_wstrb), 32'(tbl[k].mwstrb));
        chk({tbl[k].name, "_rsp_early"}, 32'(rsp_valid), 32'd0);
        mem_ready = 1'b1; mem_rdata = tbl[k].rdata;
        step();
        mem_ready = 1'b0;
        chk({tbl[k].name, "_rspvalid"}, 32'(rsp_valid), 32'd1);
        chk({tbl[k].name, "_be"}, 32'(rsp_byteenable), 32'(tbl[k].be));
        chk({tbl[k].name, "_ldata"}, rsp_ldata, tbl[k].ldata);
        chk({tbl[k].name, "_fault"}, 32'(rsp_fault), 32'd0);
        chk({tbl[k].name, "_memdrop"}, 32'(mem_valid), 32'd0);
      end
      step();
      chk({tbl[k].name, "_rsp_clear"}, 32'(rsp_valid | rsp_misalign), 32'd0);
    end

    // Timeout with mem_ready held low: exactly 16 cycles of mem_valid
    begin
      int n = 0;
      drive_req(1'b0, 2'd2, 32'hA000, 32'h0);
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (!mem_valid) break;
        n++;
        step();
      end
      chk("to_cycles", 32'(n), 32'd16);
      chk("to_rspvalid", 32'(rsp_valid), 32'd1);
      chk("to_fault", 32'(rsp_fault), 32'd1);
      chk("to_ldata", rsp_ldata, 32'd0);
      step();
      chk("to_fault_clear", 32'(rsp_fault), 32'd0);
    end

    // mem_ready on the 16th busy cycle completes normally
    drive_req(1'b0, 2'd2, 32'hB000, 32'h0);
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      mem_ready = (c == 16); mem_rdata = 32'h600DF00D;
      step();
    end
    mem_ready = 1'b0;
    chk("ready16_rspvalid", 32'(rsp_valid), 32'd1);
    chk("ready16_fault", 32'(rsp_fault), 32'd0);
    chk("ready16_ldata", rsp_ldata, 32'h600DF00D);
    step();

    // Reset on the 3rd busy cycle aborts the access silently
    drive_req(1'b1, 2'd2, 32'hC000, 32'h12345678);
    step();
    req_valid = 1'b0;
    step(); step();
    chk("rstmid_busy3", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_memvalid", 32'(mem_valid), 32'd0);
    chk("rstmid_rspvalid", 32'(rsp_valid), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    step();
    chk("rstmid_rsp_later", 32'(rsp_valid), 32'd0);

    // Random back-to-back traffic against the model
    for (int t = 0; t < 200; t++) begin
      logic        st;
      logic [1:0]  sz;
      logic [31:0] a, wd, rd;
      logic [4:0]  m;
      int          r;
      st = 1'($urandom); sz = 2'($urandom); a = $urandom; wd = $urandom;
      m = model_be(sz, a);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0; mem_ready = 1'($urandom);
        step();
        mem_ready = 1'b0;
        chk("rnd_idle_no_rsp", 32'(rsp_valid), 32'd0);
      end
      chk("rnd_req_ready", 32'(req_ready), 32'd1);
      drive_req(st, sz, a, wd);
      step();
      req_valid = 1'b0;
      if (m[4]) begin
        chk("rnd_mis_memvalid", 32'(mem_valid), 32'd0);
        chk("rnd_mis_rsp", {rsp_valid, rsp_misalign, rsp_fault, rsp_byteenable}, {1'b1, 1'b1, 1'b0, 4'h0});
        chk("rnd_mis_ldata", rsp_ldata, 32'd0);
      end else begin
        r = $urandom_range(1, 20);
        rd = $urandom;
        for (int c = 1; c <= 16; c++) begin
          chk("rnd_memvalid", 32'(mem_valid), 32'd1);
          chk("rnd_maddr", mem_addr, {a[31:2], 2'b00});
          chk("rnd_mwstrb", 32'(mem_wstrb), st ? 32'(m[3:0]) : 32'd0);
          if (st) chk("rnd_mwdata", mem_wdata, model_wdata(sz, wd));
          mem_ready = (c == r); mem_rdata = rd;
          step();
          if (c == r) break;
        end
        mem_ready = 1'b0;
        chk("rnd_memdrop", 32'(mem_valid), 32'd0);
        chk("rnd_rspvalid", 32'(rsp_valid), 32'd1);
        chk("rnd_misalign", 32'(rsp_misalign), 32'd0);
        chk("rnd_fault", 32'(rsp_fault), (r > 16) ? 32'd1 : 32'd0);
        chk("rnd_ldata", rsp_ldata, (r > 16 || st) ? 32'd0 : rd);
        if (r <= 16) chk("rnd_be", 32'(rsp_byteenable), 32'(m[3:0]));
      end
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
